// File: rtl/raytrace_pkg.sv
// raytrace_pkg: shared sizing, state/type definitions and default colours for the ray/sphere block.
package raytrace_pkg;
    localparam int DIR_W = 20;
    localparam int POS_W = 12;
    localparam int OP_W  = 2 * DIR_W + 2;
    localparam int ACC_W = 2 * (DIR_W + POS_W + 2);

    typedef logic [23:0] rgb_t;

    localparam rgb_t HIT_RGB_DEF = 24'hFF4000;
    localparam rgb_t BG_RGB_DEF  = 24'h000000;

    typedef enum logic [1:0] {IDLE, MUL, DONE} sphere_state_t;
    typedef enum logic [1:0] {ACC_A, ACC_B, ACC_C, ACC_D} acc_sel_t;
    typedef enum logic [1:0] {MAC_LOAD, MAC_ADD, MAC_SUB} mac_op_t;

    // Upper direction bits must be a pure sign extension of the kept DIR_W bits.
    function automatic logic dir_fits(input logic [32-DIR_W:0] hi);
        return (&hi) || (~|hi);
    endfunction
endpackage

// File: rtl/ray_mac_unit.sv
// ray_mac_unit: shared signed multiplier feeding four selectable accumulators (a, b, c, disc).
module ray_mac_unit
    import raytrace_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clr,
    input  logic                    en,
    input  acc_sel_t                sel,
    input  mac_op_t                 op,
    input  logic signed [OP_W-1:0]  x,
    input  logic signed [OP_W-1:0]  y,
    output logic signed [ACC_W-1:0] acc_a,
    output logic signed [ACC_W-1:0] acc_b,
    output logic signed [ACC_W-1:0] acc_c,
    output logic signed [ACC_W-1:0] acc_d
);
    logic signed [ACC_W-1:0] p, cur, nxt;

    // Products never exceed ACC_W bits, so the truncated product is exact.
    assign p = ACC_W'(x) * ACC_W'(y);

    always_comb begin
        cur = sel == ACC_A ? acc_a : sel == ACC_B ? acc_b : sel == ACC_C ? acc_c : acc_d;
        nxt = op == MAC_LOAD ? p : op == MAC_SUB ? cur - p : cur + p;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            acc_a <= '0;
            acc_b <= '0;
            acc_c <= '0;
            acc_d <= '0;
        end else if (en) begin
            if (sel == ACC_A) acc_a <= nxt;
            if (sel == ACC_B) acc_b <= nxt;
            if (sel == ACC_C) acc_c <= nxt;
            if (sel == ACC_D) acc_d <= nxt;
        end
    end
endmodule

// File: rtl/ray_sphere_tester.sv
// ray_sphere_tester: tests one ray per handshake against a sphere using a 12-step shared MAC.
// Define SPHERE_SHADE_EN to shade hits by discriminant magnitude instead of a flat colour.
module ray_sphere_tester
    import raytrace_pkg::*;
#(
`ifdef SPHERE_SHADE_EN
    parameter int   SHADE_SHIFT = 40,
`else
    parameter rgb_t HIT_RGB     = HIT_RGB_DEF,
`endif
    parameter rgb_t BG_RGB      = BG_RGB_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] ray_dir_x,
    input  logic [31:0] ray_dir_y,
    input  logic [31:0] ray_dir_z,
    input  logic [31:0] ray_index,
    input  logic [10:0] camera_pos_x,
    input  logic [10:0] camera_pos_y,
    input  logic [10:0] camera_pos_z,
    input  logic [10:0] sphere_cx,
    input  logic [10:0] sphere_cy,
    input  logic [10:0] sphere_cz,
    input  logic [10:0] sphere_r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_index,
    output logic        out_hit,
    output rgb_t        out_colour,
    output logic        range_err
);
    sphere_state_t state, state_nxt;
    logic [3:0] cnt;
    logic signed [DIR_W-1:0] dx, dy, dz;
    logic signed [POS_W-1:0] ocx, ocy, ocz, rr;
    logic signed [OP_W-1:0] op_x, op_y;
    logic signed [ACC_W-1:0] acc_a, acc_b, acc_c, acc_d;
    acc_sel_t sel;
    mac_op_t op;
    logic accept, last, hit;
    rgb_t colour;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign accept    = in_valid && in_ready;
    assign last      = state == MUL && cnt == 4'd12;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == IDLE ? (in_valid ? MUL : IDLE)
                  : state == MUL  ? (cnt == 4'd12 ? DONE : MUL)
                  : (out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt        <= '0;
            dx         <= '0;
            dy         <= '0;
            dz         <= '0;
            ocx        <= '0;
            ocy        <= '0;
            ocz        <= '0;
            rr         <= '0;
            range_err  <= 1'b0;
            out_index  <= '0;
            out_hit    <= 1'b0;
            out_colour <= '0;
        end else begin
            if (accept) begin
                cnt       <= '0;
                dx        <= ray_dir_x[DIR_W-1:0];
                dy        <= ray_dir_y[DIR_W-1:0];
                dz        <= ray_dir_z[DIR_W-1:0];
                ocx       <= signed'({1'b0, camera_pos_x}) - signed'({1'b0, sphere_cx});
                ocy       <= signed'({1'b0, camera_pos_y}) - signed'({1'b0, sphere_cy});
                ocz       <= signed'({1'b0, camera_pos_z}) - signed'({1'b0, sphere_cz});
                rr        <= {1'b0, sphere_r};
                out_index <= ray_index;
                range_err <= range_err || !dir_fits(ray_dir_x[31:DIR_W-1])
                          || !dir_fits(ray_dir_y[31:DIR_W-1]) || !dir_fits(ray_dir_z[31:DIR_W-1]);
            end else if (state == MUL) begin
                cnt <= cnt + 4'd1;
            end
            if (last) begin
                out_hit    <= hit;
                out_colour <= colour;
            end
        end
    end

    // Step schedule: a=|d|^2, b=d.oc, c=|oc|^2-r^2, then disc=b*b-a*c held in acc_d.
    always_comb begin
        op_x = '0;
        op_y = '0;
        sel  = ACC_A;
        op   = MAC_ADD;
        case (cnt)
            4'd0:  begin op_x = OP_W'(dx);  op_y = OP_W'(dx); end
            4'd1:  begin op_x = OP_W'(dy);  op_y = OP_W'(dy); end
            4'd2:  begin op_x = OP_W'(dz);  op_y = OP_W'(dz); end
            4'd3:  begin op_x = OP_W'(dx);  op_y = OP_W'(ocx); sel = ACC_B; end
            4'd4:  begin op_x = OP_W'(dy);  op_y = OP_W'(ocy); sel = ACC_B; end
            4'd5:  begin op_x = OP_W'(dz);  op_y = OP_W'(ocz); sel = ACC_B; end
            4'd6:  begin op_x = OP_W'(ocx); op_y = OP_W'(ocx); sel = ACC_C; end
            4'd7:  begin op_x = OP_W'(ocy); op_y = OP_W'(ocy); sel = ACC_C; end
            4'd8:  begin op_x = OP_W'(ocz); op_y = OP_W'(ocz); sel = ACC_C; end
            4'd9:  begin op_x = OP_W'(rr);  op_y = OP_W'(rr);  sel = ACC_C; op = MAC_SUB; end
            4'd10: begin op_x = OP_W'(acc_b); op_y = OP_W'(acc_b); sel = ACC_D; op = MAC_LOAD; end
            4'd11: begin op_x = OP_W'(acc_a); op_y = OP_W'(acc_c); sel = ACC_D; op = MAC_SUB; end
            default: ;
        endcase
    end

    ray_mac_unit u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (accept),
        .en      (state == MUL && cnt < 4'd12),
        .sel     (sel),
        .op      (op),
        .x       (op_x),
        .y       (op_y),
        .acc_a   (acc_a),
        .acc_b   (acc_b),
        .acc_c   (acc_c),
        .acc_d   (acc_d)
    );

    assign hit = !acc_d[ACC_W-1] && (acc_b[ACC_W-1] || acc_c[ACC_W-1]);

`ifdef SPHERE_SHADE_EN
    logic signed [ACC_W-1:0] shade;
    logic [7:0] s;
    assign shade  = acc_d >>> SHADE_SHIFT;
    assign s      = (shade > $signed(ACC_W'(255)) ? 8'hFF : shade[7:0]) | 8'h40;
    assign colour = hit ? {s, s, s} : BG_RGB;
`else
    assign colour = hit ? HIT_RGB : BG_RGB;
`endif
endmodule

// File: tb/tb_ray_sphere_tester.sv
// tb_ray_sphere_tester: directed self-checking bench for ray_sphere_tester.
module tb_ray_sphere_tester;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic [31:0] ray_dir_x, ray_dir_y, ray_dir_z, ray_index;
    logic [10:0] camera_pos_x, camera_pos_y, camera_pos_z;
    logic [10:0] sphere_cx, sphere_cy, sphere_cz, sphere_r;
    logic        out_valid, out_ready, out_hit, range_err;
    logic [31:0] out_index;
    logic [23:0] out_colour;

    int checks = 0;
    int errors = 0;

`ifdef SPHERE_SHADE_EN
    localparam logic [23:0] HIT_C = 24'h404040;
`else
    localparam logic [23:0] HIT_C = 24'hFF4000;
`endif
    localparam logic [23:0] MISS_C = 24'h000000;

    always #5 clk = ~clk;

    ray_sphere_tester dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ray_dir_x    (ray_dir_x),
        .ray_dir_y    (ray_dir_y),
        .ray_dir_z    (ray_dir_z),
        .ray_index    (ray_index),
        .camera_pos_x (camera_pos_x),
        .camera_pos_y (camera_pos_y),
        .camera_pos_z (camera_pos_z),
        .sphere_cx    (sphere_cx),
        .sphere_cy    (sphere_cy),
        .sphere_cz    (sphere_cz),
        .sphere_r     (sphere_r),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_index    (out_index),
        .out_hit      (out_hit),
        .out_colour   (out_colour),
        .range_err    (range_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ray(input logic [31:0] dxv, dyv, dzv, input logic [10:0] cxv, cyv, czv,
                           input logic [31:0] idx);
        ray_dir_x = dxv;
        ray_dir_y = dyv;
        ray_dir_z = dzv;
        sphere_cx = cxv;
        sphere_cy = cyv;
        sphere_cz = czv;
        ray_index = idx;
    endtask

    task automatic run_ray(input logic [31:0] dxv, dyv, dzv, input logic [10:0] cxv, cyv, czv,
                           input logic [31:0] idx, input logic exp_hit, input logic [23:0] exp_col,
                           input int hold);
        int n;
        check("in_ready_idle", in_ready, 1);
        set_ray(dxv, dyv, dzv, cxv, cyv, czv, idx);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        set_ray('1, '1, '1, '1, '1, '1, '1);
        check("in_ready_busy", in_ready, 0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, 13);
        check("out_hit", out_hit, exp_hit);
        check("out_colour", out_colour, exp_col);
        check("out_index", out_index, idx);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_colour", out_colour, exp_col);
            check("hold_index", out_index, idx);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
    endtask

    initial begin
        reset_n      = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        camera_pos_x = 11'd500;
        camera_pos_y = 11'd500;
        camera_pos_z = 11'd0;
        sphere_r     = 11'd50;
        set_ray(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_hit", out_hit, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_colour", out_colour, 0);
        check("rst_range_err", range_err, 0);

        run_ray(0, 0, 100, 500, 500, 200, 7, 1'b1, HIT_C, 0);
        run_ray(0, 0, -32'sd100, 500, 500, 200, 8, 1'b0, MISS_C, 0);
        run_ray(0, 0, 100, 550, 500, 200, 9, 1'b1, HIT_C, 0);
        run_ray(0, 0, 100, 500, 500, 200, 10, 1'b1, HIT_C, 5);
        check("range_err_clean", range_err, 0);

        run_ray(32'h0010_0000, 0, 100, 500, 500, 200, 11, 1'b1, HIT_C, 0);
        check("range_err_set", range_err, 1);
        run_ray(0, 0, -32'sd100, 500, 500, 200, 12, 1'b0, MISS_C, 0);
        check("range_err_sticky", range_err, 1);

        set_ray(0, 0, 100, 500, 500, 200, 13);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_range_err", range_err, 0);
        check("midrst_out_index", out_index, 0);
        run_ray(0, 0, 100, 550, 500, 200, 14, 1'b1, HIT_C, 0);
        run_ray(0, 0, -32'sd100, 550, 500, 200, 15, 1'b0, MISS_C, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
